// File: rtl/port_ingress_buffer.sv
// port_ingress_buffer: frame-committing ingress FIFO that only exposes whole frames and drops bad or oversized ones.
module port_ingress_buffer #(
  parameter int FIFO_DEPTH = 64,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_data_valid,
  input  logic                        rx_frame_start,
  input  logic                        rx_frame_end,
  input  logic                        rx_frame_error,
  output logic [8:0]                  port_recieve_data,
  output logic                        port_recieve_data_enable,
  input  logic                        port_receive_data_ready,
  output logic [DROP_COUNT_WIDTH-1:0] frame_drop_count,
  output logic                        frame_dropped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_DISCARD} state_t;
  state_t state, state_n;
  ptr_t wr, rd, cm, wr_n, cm_n, wa;
  logic [8:0] mem [FIFO_DEPTH];
  logic [8:0] wd;
  logic we, drop, load;
  always_comb begin
    state_n = state;
    wr_n = wr;
    cm_n = cm;
    we = 1'b0;
    wa = wr;
    wd = {1'b0, rx_data};
    drop = 1'b0;
    if (rx_data_valid) begin
      if (rx_frame_error) begin
        wr_n = cm;
        drop = state == S_RECEIVE;
        state_n = S_IDLE;
      end else if (rx_frame_start) begin
        // a start mid-frame abandons the partial frame; the new one begins at the commit pointer
        drop = state == S_RECEIVE;
        if (cm - rd == DEPTH) begin
          drop = 1'b1;
          wr_n = cm;
          state_n = rx_frame_end ? S_IDLE : S_DISCARD;
        end else begin
          we = 1'b1;
          wa = cm;
          wd = {1'b1, rx_data};
          wr_n = cm + 1'b1;
          cm_n = rx_frame_end ? cm + 1'b1 : cm;
          state_n = rx_frame_end ? S_IDLE : S_RECEIVE;
        end
      end else if (state == S_RECEIVE) begin
        if (wr - rd == DEPTH) begin
          drop = 1'b1;
          wr_n = cm;
          state_n = rx_frame_end ? S_IDLE : S_DISCARD;
        end else begin
          we = 1'b1;
          wr_n = wr + 1'b1;
          cm_n = rx_frame_end ? wr + 1'b1 : cm;
          state_n = rx_frame_end ? S_IDLE : S_RECEIVE;
        end
      end else if (state == S_DISCARD && rx_frame_end) begin
        state_n = S_IDLE;
      end
    end
  end
  assign load = (cm != rd) && (!port_recieve_data_enable || port_receive_data_ready);
  always_ff @(posedge clock)
    if (we) mem[wa[AW-1:0]] <= wd;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      wr <= '0;
      rd <= '0;
      cm <= '0;
      port_recieve_data <= '0;
      port_recieve_data_enable <= 1'b0;
      frame_drop_count <= '0;
      frame_dropped <= 1'b0;
    end else begin
      state <= state_n;
      wr <= wr_n;
      cm <= cm_n;
      frame_dropped <= drop;
      if (drop && !(&frame_drop_count)) frame_drop_count <= frame_drop_count + 1'b1;
      if (load) begin
        port_recieve_data <= mem[rd[AW-1:0]];
        port_recieve_data_enable <= 1'b1;
        rd <= rd + 1'b1;
      end else if (port_receive_data_ready) begin
        port_recieve_data_enable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_port_ingress_buffer.sv
// tb_port_ingress_buffer: directed vector table plus multi-cycle sequences for the ingress buffer.
module tb_port_ingress_buffer;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;
  logic [7:0] rx_data;
  logic rx_data_valid, rx_frame_start, rx_frame_end, rx_frame_error;
  logic [8:0] port_recieve_data;
  logic port_recieve_data_enable, port_receive_data_ready;
  logic [1:0] frame_drop_count;
  logic frame_dropped;

  port_ingress_buffer #(.FIFO_DEPTH(8), .DROP_COUNT_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_frame_start(rx_frame_start), .rx_frame_end(rx_frame_end), .rx_frame_error(rx_frame_error),
    .port_recieve_data(port_recieve_data), .port_recieve_data_enable(port_recieve_data_enable),
    .port_receive_data_ready(port_receive_data_ready), .frame_drop_count(frame_drop_count),
    .frame_dropped(frame_dropped)
  );

  typedef struct {
    logic v, s, e, er;
    logic [7:0] d;
    logic een;
    logic [8:0] edat;
    logic [1:0] ecnt;
    logic edrp;
  } vec_t;

  int n_vec = 0, n_err = 0;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  vec_t tbl[25];

  function automatic vec_t mk(logic v, s, e, er, logic [7:0] d, logic een, logic [8:0] edat, logic [1:0] ecnt, logic edrp);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.er = er; r.d = d;
    r.een = een; r.edat = edat; r.ecnt = ecnt; r.edrp = edrp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, s, e, er, input logic [7:0] d);
    rx_data_valid = v; rx_frame_start = s; rx_frame_end = e; rx_frame_error = er; rx_data = d;
    @(posedge clock); #1;
    rx_data_valid = 0; rx_frame_start = 0; rx_frame_end = 0; rx_frame_error = 0; rx_data = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
  endtask

  // ready pattern either constant 1 or alternating; held data must not change while stalled
  task automatic drain(input int n, input bit tog);
    logic [8:0] hold;
    logic held;
    held = 0;
    hold = '0;
    got = {};
    for (int i = 0; i < n; i++) begin
      port_receive_data_ready = tog ? (i % 2 == 0) : 1'b1;
      if (held) chk("stable_hold", {port_recieve_data_enable, port_recieve_data}, {1'b1, hold});
      held = port_recieve_data_enable && !port_receive_data_ready;
      hold = port_recieve_data;
      if (port_recieve_data_enable && port_receive_data_ready) got.push_back(port_recieve_data);
      @(posedge clock); #1;
    end
  endtask

  task automatic chk_q(input string nm);
    chk({nm, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nm, got[i], exp_q[i]);
  endtask

  initial begin
    int pulses;
    logic en_seen;
    reset = 1; rx_data = 0; rx_data_valid = 0; rx_frame_start = 0; rx_frame_end = 0;
    rx_frame_error = 0; port_receive_data_ready = 1;
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
    chk("reset_en", port_recieve_data_enable, 0);
    chk("reset_data", port_recieve_data, 0);
    chk("reset_cnt", frame_drop_count, 0);
    chk("reset_drp", frame_dropped, 0);

    tbl[0]  = mk(1,1,0,0,8'hAA, 0,9'h000,0,0);
    tbl[1]  = mk(1,0,0,0,8'hBB, 0,9'h000,0,0);
    tbl[2]  = mk(1,0,1,0,8'hCC, 0,9'h000,0,0);
    tbl[3]  = mk(0,0,0,0,8'h00, 1,9'h1AA,0,0);
    tbl[4]  = mk(0,0,0,0,8'h00, 1,9'h0BB,0,0);
    tbl[5]  = mk(0,0,0,0,8'h00, 1,9'h0CC,0,0);
    tbl[6]  = mk(0,0,0,0,8'h00, 0,9'h000,0,0);
    tbl[7]  = mk(1,1,1,0,8'h55, 0,9'h000,0,0);
    tbl[8]  = mk(0,0,0,0,8'h00, 1,9'h155,0,0);
    tbl[9]  = mk(0,0,0,0,8'h00, 0,9'h000,0,0);
    tbl[10] = mk(1,1,0,0,8'h11, 0,9'h000,0,0);
    tbl[11] = mk(1,0,0,0,8'h22, 0,9'h000,0,0);
    tbl[12] = mk(1,1,0,0,8'h33, 0,9'h000,1,1);
    tbl[13] = mk(1,0,1,0,8'h44, 0,9'h000,1,0);
    tbl[14] = mk(0,0,0,0,8'h00, 1,9'h133,1,0);
    tbl[15] = mk(0,0,0,0,8'h00, 1,9'h044,1,0);
    tbl[16] = mk(0,0,0,0,8'h00, 0,9'h000,1,0);
    tbl[17] = mk(1,1,0,0,8'h01, 0,9'h000,1,0);
    tbl[18] = mk(1,0,0,0,8'h02, 0,9'h000,1,0);
    tbl[19] = mk(1,0,0,1,8'h03, 0,9'h000,2,1);
    tbl[20] = mk(1,0,0,0,8'h04, 0,9'h000,2,0);
    tbl[21] = mk(1,0,1,0,8'h05, 0,9'h000,2,0);
    tbl[22] = mk(1,1,1,0,8'h66, 0,9'h000,2,0);
    tbl[23] = mk(0,0,0,0,8'h00, 1,9'h166,2,0);
    tbl[24] = mk(0,0,0,0,8'h00, 0,9'h000,2,0);
    for (int i = 0; i < 25; i++) begin
      port_receive_data_ready = 1;
      cyc(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].er, tbl[i].d);
      chk($sformatf("vec%0d_en", i), port_recieve_data_enable, tbl[i].een);
      if (tbl[i].een) chk($sformatf("vec%0d_data", i), port_recieve_data, tbl[i].edat);
      chk($sformatf("vec%0d_cnt", i), frame_drop_count, tbl[i].ecnt);
      chk($sformatf("vec%0d_drp", i), frame_dropped, tbl[i].edrp);
    end

    // counter saturates at all-ones but still pulses
    cyc(1,1,0,0,8'h77);
    cyc(1,0,0,1,8'h78);
    chk("sat_cnt3", frame_drop_count, 3);
    chk("sat_drp1", frame_dropped, 1);
    cyc(1,1,0,0,8'h79);
    cyc(1,0,0,1,8'h7A);
    chk("sat_cnt_hold", frame_drop_count, 3);
    chk("sat_drp2", frame_dropped, 1);

    // oversized frame with a stalled consumer
    do_reset();
    port_receive_data_ready = 0;
    pulses = 0;
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, i == 0, i == 9, 0, 8'h90 + 8'(i));
      if (frame_dropped) pulses++;
      if (port_recieve_data_enable) en_seen = 1;
    end
    cyc(0,0,0,0,8'h00);
    if (frame_dropped) pulses++;
    chk("big_pulses", pulses, 1);
    chk("big_cnt", frame_drop_count, 1);
    chk("big_en", en_seen, 0);
    cyc(1,1,0,0,8'hA1);
    cyc(1,0,0,0,8'hA2);
    cyc(1,0,1,0,8'hA3);
    drain(8, 0);
    exp_q = {9'h1A1, 9'h0A2, 9'h0A3};
    chk_q("after_big");

    // two frames drained with alternating ready
    port_receive_data_ready = 0;
    cyc(1,1,0,0,8'hB1);
    cyc(1,0,0,0,8'hB2);
    cyc(1,0,1,0,8'hB3);
    cyc(1,1,0,0,8'hC1);
    cyc(1,0,1,0,8'hC2);
    drain(20, 1);
    exp_q = {9'h1B1, 9'h0B2, 9'h0B3, 9'h1C1, 9'h0C2};
    chk_q("toggle");

    // reset while a frame is being output
    port_receive_data_ready = 0;
    cyc(1,1,0,0,8'hD1);
    cyc(1,0,0,0,8'hD2);
    cyc(1,0,1,0,8'hD3);
    cyc(0,0,0,0,8'h00);
    chk("mid_en_before", port_recieve_data_enable, 1);
    port_receive_data_ready = 1;
    cyc(0,0,0,0,8'h00);
    do_reset();
    chk("mid_rst_en", port_recieve_data_enable, 0);
    chk("mid_rst_cnt", frame_drop_count, 0);
    cyc(1,0,1,0,8'hEE);
    en_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0,0,0,0,8'h00);
      if (port_recieve_data_enable) en_seen = 1;
    end
    chk("post_rst_nostart", en_seen, 0);
    cyc(1,1,1,0,8'h88);
    drain(6, 0);
    exp_q = {9'h188};
    chk_q("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/port_ingress_buffer.md
PORT_INGRESS_BUFFER -- requirements
Module: port_ingress_buffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, meaning byte entries stored; a power of two, at least 8.
REQ-002 SHALL have parameter DROP_COUNT_WIDTH, default 16, meaning width of the dropped-frame counter.
REQ-003 clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the port MAC.
REQ-006 rx_data_valid  input  1  rx_data and the flags are valid this cycle; no backpressure.
REQ-007 rx_frame_start  input  1  qualifies the first byte of a frame.
REQ-008 rx_frame_end  input  1  qualifies the last byte of a frame; may coincide with rx_frame_start.
REQ-009 rx_frame_error  input  1  aborts the current frame; the byte in that cycle is discarded.
REQ-010 port_recieve_data  output  9  bit 8 = start-of-frame marker, bits 7:0 = byte.
REQ-011 port_recieve_data_enable  output  1  port_recieve_data holds a valid byte.
REQ-012 port_receive_data_ready  input  1  consumer accepts the byte this cycle.
REQ-013 frame_drop_count  output  DROP_COUNT_WIDTH  frames dropped since reset; saturating.
REQ-014 frame_dropped  output  1  one-cycle pulse per dropped frame.

Function
REQ-015 A byte SHALL be transferred out on a rising edge where port_recieve_data_enable and port_receive_data_ready are both 1; port_receive_data_ready while enable is 0 has no effect.
REQ-016 Output data/enable SHALL be registered (show-ahead output register) and SHALL stay stable until transferred.
REQ-017 Storage SHALL be a FIFO_DEPTH x 9 array; read, write and commit pointers SHALL be $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-018 Full SHALL mean write pointer minus read pointer equals FIFO_DEPTH; the output register is not counted.
REQ-019 Only bytes between read and commit pointers SHALL be visible to the read side; partial frames are never output.
REQ-020 Write FSM states: S_IDLE, S_RECEIVE, S_DISCARD.
REQ-021 S_IDLE: valid&start SHALL write {1,rx_data} and go S_RECEIVE, or commit immediately and stay S_IDLE if end is also 1; valid bytes without start SHALL be ignored.
REQ-022 S_RECEIVE: valid byte without start SHALL write {0,rx_data}; with end SHALL advance commit pointer to include it and go S_IDLE.
REQ-023 S_RECEIVE: valid&start SHALL drop the partial frame (write pointer := commit pointer, count one drop) and start the new frame per REQ-021 in the same cycle.
REQ-024 Any state: valid&error SHALL rewind write pointer to commit pointer, count one drop if a frame was in progress, and go S_IDLE; error overrides start/end.
REQ-025 Write needed while full SHALL rewind write pointer to commit pointer, count one drop, and go S_DISCARD, or S_IDLE if end is also 1.
REQ-026 S_DISCARD: SHALL ignore bytes until valid&end (go S_IDLE) or valid&start (restart per REQ-021); no further drop is counted for the same frame.
REQ-027 Frames longer than FIFO_DEPTH bytes SHALL therefore always be dropped.
REQ-028 Output register SHALL load mem[read pointer] and increment read pointer when committed data exists and the register is empty or being transferred that cycle; back-to-back transfers sustain one byte per clock.
REQ-029 Latency: end byte sampled at edge N with the FIFO empty SHALL make the first byte visible with enable=1 after edge N+1.
REQ-030 Each drop SHALL pulse frame_dropped for one cycle and increment frame_drop_count, saturating at all-ones.
REQ-031 Write and read in the same cycle SHALL both take effect; full is evaluated on pre-edge pointers.

Reset
REQ-032 reset SHALL clear pointers, output register, port_recieve_data (0), port_recieve_data_enable (0), frame_drop_count (0), frame_dropped (0), FSM to S_IDLE; array contents need not be cleared.
REQ-033 reset mid-frame SHALL discard all stored and partial frames; the next accepted byte must carry start.

Verification
REQ-034 Frame AA,BB,CC (start on AA, end on CC), ready=1 -> outputs 1AA,0BB,0CC on consecutive cycles, first after the edge following CC's edge.
REQ-035 Single-byte frame 55 with start&end -> one output 155, enable then low.
REQ-036 FIFO_DEPTH=8, ready=0, 10-byte frame -> frame_dropped pulses once, count=1, enable stays 0; following 3-byte frame output intact.
REQ-037 Frame 11,22 then start on 33 without end, then end on 44 -> output 133,044 only; count=1.
REQ-038 Error asserted on 3rd byte of 5-byte frame -> nothing output, count=1, FSM S_IDLE.
REQ-039 Two committed frames, ready toggling 1/0 -> every byte output once, in order, data stable while ready=0; reset mid-output -> enable 0 next cycle, count 0.
